load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the core's execute stage and the 32-bit, word-organised data memory (1 KB, little-endian, posedge full-word write, combinational read while write_en is low).
- Turns byte, halfword and word load/store requests into word-aligned memory accesses.
- Sub-word stores use a read-modify-write sequence, because the memory supports full-word writes only.
- Loads are sign- or zero-extended. Results return through a valid/ready request and a single-cycle response pulse.

Parameters:
- MEM_BYTES, 1024, size of the attached memory in bytes; a power of two and a multiple of 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal and is treated as word.
- req_unsigned  in  1  1 = zero-extend loads (LBU/LHU); ignored for stores and word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle pulse marking completion of the accepted request.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid; misaligned or out-of-range access.
- mem_write_en  out  1  to memory write_en.
- mem_addr  out  32  to memory A; always word-aligned.
- mem_w_data  out  32  to memory w_data.
- mem_r_data  in  32  from memory r_data.

Behaviour:
- Reset: synchronous, active-high. All outputs and internal registers are 0 and the state is IDLE, except req_ready = 1 (combinationally in IDLE). Reset mid-operation aborts the sequence with no memory write and no rsp_valid.
- Handshake: a request is accepted on a rising edge where req_valid & req_ready. All request fields are latched at that edge; inputs are don't-care afterwards.
- req_ready = (state == IDLE). Only one request is outstanding, and there is no back-pressure on the response.
- States: IDLE, RD (memory read cycle), WR (memory write cycle), RSP.
- Transitions from IDLE on accept:
  - error -> RSP
  - load -> RD
  - word store -> WR
  - byte or half store -> RD
- Transitions from RD:
  - load -> RSP; the extended data is captured into rsp_rdata at this edge.
  - store -> WR; the merged word is captured into a write register at this edge.
- WR -> RSP.
- RSP -> IDLE. rsp_valid = (state == RSP).
- Latency from the accept edge to the rsp_valid cycle:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- mem_addr = {addr_q[31:2], 2'b00} in RD and WR, 0 otherwise.
- mem_write_en = 1 only in WR.
- mem_w_data = merged word in WR, 0 otherwise.
- Merge: the selected byte lane(s) of the read word are replaced by the low byte/half of the store data. The byte lane is addr[1:0]; the half lane is addr[1].
- Load extract:
  - byte at lane addr[1:0], half at lane addr[1].
  - Sign-extended from bit 7 or bit 15 unless req_unsigned; word loads pass through unchanged.
- Error (checking compiled in):
  - misaligned: half with addr[0] = 1, or word with addr[1:0] != 0
  - out of range: addr >= MEM_BYTES
  - On error there is no memory access and rsp_err = 1 in RSP.
- Back-to-back requests: a new request can be accepted in the cycle after RSP. req_valid held high during RSP is not accepted until IDLE.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: the error detection above is active.
- Undefined:
  - rsp_err is tied to 0 and the error path is removed.
  - Misaligned halves use lane addr[1]; misaligned words ignore addr[1:0].
  - Addresses wrap modulo MEM_BYTES, with upper address bits passed through as the memory ignores them.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10
  - the state enum IDLE/RD/WR/RSP
- One combinational sub-module, lsu_lane_unit (ports: size, addr[1:0], unsigned, wdata, rword -> merged word, extended load data), instantiated once.

Test Plan:
- Word store 0xDEADBEEF at 0x10, then LW 0x10 -> one write cycle with mem_w_data = 0xDEADBEEF; rsp_rdata = 0xDEADBEEF 2 cycles after accept; rsp_err = 0.
- SB 0xAA at 0x11 over 0x11223344 -> RD then WR with mem_w_data = 0x1122AA44; rsp_valid 3 cycles after accept; LB 0x11 -> 0xFFFFFFAA, LBU 0x11 -> 0x000000AA.
- SH 0x8001 at 0x12 over 0x11223344 -> 0x80013344; LH 0x12 -> 0xFFFF8001, LHU -> 0x00008001.
- With the macro defined: LH at 0x13 and LW at 0x402 -> rsp_err = 1 one cycle after accept, mem_write_en never asserted, rsp_rdata = 0.
- rst asserted during the WR cycle of an SB -> memory unchanged, no rsp_valid, req_ready = 1 on the next cycle.
- req_valid held high for 3 back-to-back LW requests -> req_ready low except in IDLE, one rsp_valid per request, accepts spaced 3 cycles apart.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings, FSM states and request payload for the load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RSP  = 2'b11
    } lsu_state_t;

    typedef struct packed {
        logic            store;
        logic [1:0]      size;
        logic            is_unsigned;
        logic [1:0]      lane;
        logic [XLEN-1:0] wdata;
    } lsu_req_t;

    // Size 2'b11 is checked like a word access.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            default: bad = (lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Byte/half lane steering: store merge into a read word and load extraction with extension.
module lsu_lane_unit
    import lsu_pkg::*;
(
    input  logic [1:0]      size,
    input  logic [1:0]      addr,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rword,
    output logic [XLEN-1:0] merged,
    output logic [XLEN-1:0] ldata
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [4:0]  byte_sh;

    always_comb begin
        byte_sh = {addr, 3'b000};
        byte_v  = rword[byte_sh +: 8];
        half_v  = addr[1] ? rword[31:16] : rword[15:0];
        merged  = rword;
        ldata   = rword;
        case (size)
            SZ_BYTE: begin
                merged[byte_sh +: 8] = wdata[7:0];
                ldata = is_unsigned ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                if (addr[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
                ldata = is_unsigned ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            end
            default: begin
                merged = wdata;
                ldata  = rword;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sub-word accesses onto a word-wide memory, RMW for sub-word stores.
// Define LSU_MISALIGN_CHECK_EN to enable misalignment / range error reporting.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            mem_write_en,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_w_data,
    input  logic [XLEN-1:0] mem_r_data
);

    localparam logic [XLEN-1:0] OFFSET_MASK = XLEN'(MEM_BYTES - 1);
    localparam logic [XLEN-1:0] WORD_MASK   = XLEN'(MEM_BYTES - 4);

    lsu_state_t      state;
    lsu_req_t        req_q;
    logic            wr_q;
    logic            req_err_c;
    logic            sub_word_c;
    logic [XLEN-1:0] word_addr_c;
    logic [XLEN-1:0] merged_c;
    logic [XLEN-1:0] ldata_c;

    // Offset wraps inside the memory; upper bits pass through untouched.
    assign word_addr_c = (req_addr & ~OFFSET_MASK) | (req_addr & WORD_MASK);
    assign sub_word_c  = (req_size == SZ_BYTE) || (req_size == SZ_HALF);

`ifdef LSU_MISALIGN_CHECK_EN
    assign req_err_c = misaligned(req_size, req_addr[1:0]) || (req_addr >= XLEN'(MEM_BYTES));
`else
    assign req_err_c = 1'b0;
`endif

    // A reset landing in the write cycle must not commit the write.
    assign mem_write_en = wr_q & ~rst;

    lsu_lane_unit u_lane (
        .size        (req_q.size),
        .addr        (req_q.lane),
        .is_unsigned (req_q.is_unsigned),
        .wdata       (req_q.wdata),
        .rword       (mem_r_data),
        .merged      (merged_c),
        .ldata       (ldata_c)
    );

    // Sequencer with all outputs registered on the state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_q      <= '0;
            wr_q       <= 1'b0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            mem_addr   <= '0;
            mem_w_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready         <= 1'b0;
                        req_q.store       <= req_we;
                        req_q.size        <= req_size;
                        req_q.is_unsigned <= req_unsigned;
                        req_q.lane        <= req_addr[1:0];
                        req_q.wdata       <= req_wdata;
                        if (req_err_c) begin
                            state     <= RSP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (req_we && !sub_word_c) begin
                            state      <= WR;
                            wr_q       <= 1'b1;
                            mem_addr   <= word_addr_c;
                            mem_w_data <= req_wdata;
                        end else begin
                            state    <= RD;
                            mem_addr <= word_addr_c;
                        end
                    end
                end
                RD: begin
                    if (req_q.store) begin
                        state      <= WR;
                        wr_q       <= 1'b1;
                        mem_w_data <= merged_c;
                    end else begin
                        state     <= RSP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= ldata_c;
                        mem_addr  <= '0;
                    end
                end
                WR: begin
                    state      <= RSP;
                    wr_q       <= 1'b0;
                    mem_addr   <= '0;
                    mem_w_data <= '0;
                    rsp_valid  <= 1'b1;
                    rsp_rdata  <= '0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 1 KB word memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_w_data;
    logic [31:0] mem_r_data;

    logic [31:0] mem [0:255];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr[9:2]] <= mem_w_data;
    end
    assign mem_r_data = mem_write_en ? 32'h0 : mem[mem_addr[9:2]];

    load_store_unit #(.MEM_BYTES(1024)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_write_en (mem_write_en),
        .mem_addr     (mem_addr),
        .mem_w_data   (mem_w_data),
        .mem_r_data   (mem_r_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request from IDLE; reports latency, response and any write seen.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er,
                          output int nwr, output logic [31:0] wdat, output logic [31:0] wadr);
        lat = 0; rd = 32'h0; er = 1'b0; nwr = 0; wdat = 32'h0; wadr = 32'h0;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        tick();
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_wdata = 32'h5A5A_5A5A;
        req_size = SZ_BYTE; req_unsigned = ~uns; req_we = ~we;
        for (int k = 1; k <= 6; k++) begin
            if (mem_write_en) begin
                nwr++; wdat = mem_w_data; wadr = mem_addr;
            end
            if (rsp_valid) begin
                lat = k; rd = rsp_rdata; er = rsp_err;
                break;
            end
            tick();
        end
        tick();
    endtask

    int          lat, nwr, acc, npulse, last_t;
    logic [31:0] rd, wdat, wadr;
    logic        er;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_WORD;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        tick(); tick();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_mem_we", 32'(mem_write_en), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_w_data, 32'h0);
        rst = 1'b0;
        tick();

        // Word store then word load
        do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, nwr, wdat, wadr);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_nwr", 32'(nwr), 32'd1);
        chk("sw_wdata", wdat, 32'hDEADBEEF);
        chk("sw_waddr", wadr, 32'h10);
        chk("sw_err", 32'(er), 32'd0);
        chk("sw_rdata", rd, 32'h0);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, lat, rd, er, nwr, wdat, wadr);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_err", 32'(er), 32'd0);
        chk("lw_nwr", 32'(nwr), 32'd0);

        // Byte store read-modify-write and byte loads
        do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h11223344, lat, rd, er, nwr, wdat, wadr);
        do_req(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h123456AA, lat, rd, er, nwr, wdat, wadr);
        chk("sb_lat", 32'(lat), 32'd3);
        chk("sb_nwr", 32'(nwr), 32'd1);
        chk("sb_wdata", wdat, 32'h1122AA44);
        chk("sb_waddr", wadr, 32'h10);
        do_req(1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, lat, rd, er, nwr, wdat, wadr);
        chk("lb_rdata", rd, 32'hFFFFFFAA);
        chk("lb_lat", 32'(lat), 32'd2);
        do_req(1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, lat, rd, er, nwr, wdat, wadr);
        chk("lbu_rdata", rd, 32'h000000AA);
        do_req(1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0, lat, rd, er, nwr, wdat, wadr);
        chk("lb_pos_rdata", rd, 32'h00000044);
        do_req(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, lat, rd, er, nwr, wdat, wadr);
        chk("lb_lane3_rdata", rd, 32'h00000011);

        // Half store and half loads
        do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h11223344, lat, rd, er, nwr, wdat, wadr);
        do_req(1'b1, SZ_HALF, 1'b0, 32'h12, 32'hFFFF8001, lat, rd, er, nwr, wdat, wadr);
        chk("sh_lat", 32'(lat), 32'd3);
        chk("sh_wdata", wdat, 32'h80013344);
        do_req(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, lat, rd, er, nwr, wdat, wadr);
        chk("lh_rdata", rd, 32'hFFFF8001);
        do_req(1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, lat, rd, er, nwr, wdat, wadr);
        chk("lhu_rdata", rd, 32'h00008001);
        do_req(1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0, lat, rd, er, nwr, wdat, wadr);
        chk("lh_low_rdata", rd, 32'h00003344);

`ifdef LSU_MISALIGN_CHECK_EN
        do_req(1'b0, SZ_HALF, 1'b0, 32'h13, 32'h0, lat, rd, er, nwr, wdat, wadr);
        chk("lh_mis_lat", 32'(lat), 32'd1);
        chk("lh_mis_err", 32'(er), 32'd1);
        chk("lh_mis_rdata", rd, 32'h0);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h402, 32'h0, lat, rd, er, nwr, wdat, wadr);
        chk("lw_oob_lat", 32'(lat), 32'd1);
        chk("lw_oob_err", 32'(er), 32'd1);
        chk("lw_oob_rdata", rd, 32'h0);
        do_req(1'b1, SZ_BYTE, 1'b0, 32'h400, 32'h77, lat, rd, er, nwr, wdat, wadr);
        chk("sb_oob_err", 32'(er), 32'd1);
        chk("sb_oob_nwr", 32'(nwr), 32'd0);
        do_req(1'b1, SZ_WORD, 1'b0, 32'h11, 32'h99999999, lat, rd, er, nwr, wdat, wadr);
        chk("sw_mis_err", 32'(er), 32'd1);
        chk("sw_mis_nwr", 32'(nwr), 32'd0);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, lat, rd, er, nwr, wdat, wadr);
        chk("err_mem_kept", rd, 32'h80013344);
`else
        do_req(1'b0, SZ_HALF, 1'b0, 32'h13, 32'h0, lat, rd, er, nwr, wdat, wadr);
        chk("lh_mis_lat", 32'(lat), 32'd2);
        chk("lh_mis_err", 32'(er), 32'd0);
        chk("lh_mis_rdata", rd, 32'hFFFF8001);
        do_req(1'b1, SZ_WORD, 1'b0, 32'h0, 32'h0BADF00D, lat, rd, er, nwr, wdat, wadr);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h402, 32'h0, lat, rd, er, nwr, wdat, wadr);
        chk("lw_wrap_lat", 32'(lat), 32'd2);
        chk("lw_wrap_err", 32'(er), 32'd0);
        chk("lw_wrap_rdata", rd, 32'h0BADF00D);
`endif

        // Reset during the write cycle of a byte store
        do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h11223344, lat, rd, er, nwr, wdat, wadr);
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h55;
        tick();
        req_valid = 1'b0;
        tick();
        chk("rstwr_we_before", 32'(mem_write_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstwr_we_gated", 32'(mem_write_en), 32'd0);
        tick();
        chk("rstwr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstwr_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        tick();
        chk("rstwr_ready_next", 32'(req_ready), 32'd1);
        chk("rstwr_rsp_valid_next", 32'(rsp_valid), 32'd0);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, lat, rd, er, nwr, wdat, wadr);
        chk("rstwr_mem_kept", rd, 32'h11223344);

        // Three back-to-back word loads with req_valid held high
        req_valid = 1'b1; req_we = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;
        acc = 0; npulse = 0; last_t = 0;
        for (int t = 0; t < 10; t++) begin
            chk("b2b_ready", 32'(req_ready), (t % 3 == 0) ? 32'd1 : 32'd0);
            if (rsp_valid) begin
                npulse++;
                chk("b2b_rdata", rsp_rdata, 32'h11223344);
            end
            if (req_valid && req_ready) begin
                if (acc > 0) chk("b2b_spacing", 32'(t - last_t), 32'd3);
                last_t = t;
                acc++;
            end
            tick();
            if (acc == 3) req_valid = 1'b0;
        end
        chk("b2b_accepts", 32'(acc), 32'd3);
        chk("b2b_pulses", 32'(npulse), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
